// File: rtl/mem_access_if.sv
// Byte-wide synchronous RAM port between the memory-access stage and its RAM.
interface mem_access_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] ram_addr_o;
   logic                  ram_wr_o;
   logic [7:0]            ram_dout_o;
   logic [7:0]            ram_din_i;

   modport master (output ram_addr_o, output ram_wr_o, output ram_dout_o, input ram_din_i);
   modport slave  (input ram_addr_o, input ram_wr_o, input ram_dout_o, output ram_din_i);
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: serialises B/H/W loads and stores onto an 8-bit RAM port,
// stalls upstream while busy and returns extended load data toward write-back.
module mem_access #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_enable_i,
   input  logic                store_enable_i,
   input  logic [31:0]         load_store_addr_i,
   input  logic [2:0]          funct3_i,
   input  logic [31:0]         store_data_i,
   input  logic [31:0]         rd_data_i,
   input  logic [4:0]          rd_addr_i,
   input  logic                rd_write_enable_i,
   output logic [31:0]         rd_data_o,
   output logic [4:0]          rd_addr_o,
   output logic                rd_write_enable_o,
   output logic                stall_req_o,
   mem_access_if.master        ram
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_e;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] sdata_q, sdata_d;
   logic [31:0] ldata_q, ldata_d;
   logic        zext_q, zext_d;
   logic        store_q, store_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic        rd_we_q, rd_we_d;

   logic                  req;
   logic [31:0]           byte_addr;
   logic [31:0]           load_ext;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_wr;
   logic [7:0]            ram_dout;

   // Accept term is gated by rst_n so no stall is requested while held in reset.
   assign req       = (load_enable_i | store_enable_i) & rst_n;
   assign byte_addr = addr_q + {29'd0, cnt_q};

   always_comb begin
      load_ext = ldata_q;
      unique case (size_q)
         3'd1:    load_ext = zext_q ? {24'd0, ldata_q[7:0]}  : {{24{ldata_q[7]}}, ldata_q[7:0]};
         3'd2:    load_ext = zext_q ? {16'd0, ldata_q[15:0]} : {{16{ldata_q[15]}}, ldata_q[15:0]};
         default: load_ext = ldata_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         size_q    <= '0;
         addr_q    <= '0;
         sdata_q   <= '0;
         ldata_q   <= '0;
         zext_q    <= 1'b0;
         store_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_we_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         sdata_q   <= sdata_d;
         ldata_q   <= ldata_d;
         zext_q    <= zext_d;
         store_q   <= store_d;
         rd_addr_q <= rd_addr_d;
         rd_we_q   <= rd_we_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      size_d            = size_q;
      addr_d            = addr_q;
      sdata_d           = sdata_q;
      ldata_d           = ldata_q;
      zext_d            = zext_q;
      store_d           = store_q;
      rd_addr_d         = rd_addr_q;
      rd_we_d           = rd_we_q;
      ram_addr          = '0;
      ram_wr            = 1'b0;
      ram_dout          = '0;
      stall_req_o       = 1'b0;
      rd_data_o         = '0;
      rd_addr_o         = '0;
      rd_write_enable_o = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               stall_req_o = 1'b1;
               addr_d      = load_store_addr_i;
               sdata_d     = store_data_i;
               zext_d      = funct3_i[2];
               size_d      = funct3_i[1] ? 3'd4 : (funct3_i[0] ? 3'd2 : 3'd1);
               store_d     = store_enable_i;
               rd_addr_d   = rd_addr_i;
               rd_we_d     = rd_write_enable_i;
               ldata_d     = '0;
               cnt_d       = '0;
               state_d     = store_enable_i ? S_STORE : S_LOAD;
            end else begin
               rd_data_o         = rd_data_i;
               rd_addr_o         = rd_addr_i;
               rd_write_enable_o = rd_write_enable_i;
            end
         end
         S_STORE: begin
            stall_req_o = 1'b1;
            ram_addr    = byte_addr[ADDR_WIDTH-1:0];
            ram_wr      = 1'b1;
            ram_dout    = sdata_q[{cnt_q[1:0], 3'b000} +: 8];
            if (cnt_q == size_q - 3'd1) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_LOAD: begin
            stall_req_o = 1'b1;
            if (cnt_q < size_q) ram_addr = byte_addr[ADDR_WIDTH-1:0];
            // Data for byte k-1 arrives while byte k is being addressed.
            for (int unsigned i = 0; i < 4; i++) begin
               if ({29'd0, cnt_q} == i + 1) ldata_d[8*i +: 8] = ram.ram_din_i;
            end
            if (cnt_q == size_q) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_DONE: begin
            if (!store_q) begin
               rd_data_o         = load_ext;
               rd_addr_o         = rd_addr_q;
               rd_write_enable_o = rd_we_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ram.ram_addr_o = ram_addr;
   assign ram.ram_wr_o   = ram_wr;
   assign ram.ram_dout_o = ram_dout;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table of load/store transactions plus
// hand sequences for reset release, pass-through and mid-load reset.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_enable_i, store_enable_i;
   logic [31:0] load_store_addr_i, store_data_i, rd_data_i;
   logic [2:0]  funct3_i;
   logic [4:0]  rd_addr_i;
   logic        rd_write_enable_i;
   logic [31:0] rd_data_o;
   logic [4:0]  rd_addr_o;
   logic        rd_write_enable_o;
   logic        stall_req_o;

   mem_access_if #(.ADDR_WIDTH(32)) bus ();

   mem_access #(.ADDR_WIDTH(32)) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .load_enable_i     (load_enable_i),
      .store_enable_i    (store_enable_i),
      .load_store_addr_i (load_store_addr_i),
      .funct3_i          (funct3_i),
      .store_data_i      (store_data_i),
      .rd_data_i         (rd_data_i),
      .rd_addr_i         (rd_addr_i),
      .rd_write_enable_i (rd_write_enable_i),
      .rd_data_o         (rd_data_o),
      .rd_addr_o         (rd_addr_o),
      .rd_write_enable_o (rd_write_enable_o),
      .stall_req_o       (stall_req_o),
      .ram               (bus)
   );

   always #5 clk = ~clk;

   // RAM model: 4 KiB window on the low address bits, plus a side preload port.
   logic [7:0]  mem [0:4095];
   int unsigned wr_cnt = 0;
   logic        pl_en = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [7:0]  pl_data = '0;

   always @(posedge clk) begin
      if (bus.ram_wr_o) begin
         mem[bus.ram_addr_o[11:0]] <= bus.ram_dout_o;
         wr_cnt <= wr_cnt + 1;
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end
      bus.ram_din_i <= mem[bus.ram_addr_o[11:0]];
   end

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        st;
      logic        ld;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [4:0]  rda;
      logic        rdwe;
      int unsigned pre_n;
      logic [31:0] pre;
      logic [31:0] exp_data;
      logic        exp_we;
      int unsigned exp_done;
      int unsigned exp_stalls;
      int unsigned exp_rdc;
      int unsigned exp_nwr;
      logic [31:0] a1;
      logic [31:0] a2;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(input logic st, input logic ld, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] rda, input logic rdwe,
                               input int unsigned pre_n, input logic [31:0] pre,
                               input logic [31:0] exp_data, input logic exp_we,
                               input int unsigned exp_done, input int unsigned exp_stalls,
                               input int unsigned exp_rdc, input int unsigned exp_nwr,
                               input logic [31:0] a1, input logic [31:0] a2);
      vec_t v;
      v.st = st; v.ld = ld; v.f3 = f3; v.addr = addr; v.sdata = sdata;
      v.rda = rda; v.rdwe = rdwe; v.pre_n = pre_n; v.pre = pre;
      v.exp_data = exp_data; v.exp_we = exp_we; v.exp_done = exp_done;
      v.exp_stalls = exp_stalls; v.exp_rdc = exp_rdc; v.exp_nwr = exp_nwr;
      v.a1 = a1; v.a2 = a2;
      return v;
   endfunction

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_addr = a[11:0]; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      load_enable_i     = v.ld;
      store_enable_i    = v.st;
      funct3_i          = v.f3;
      load_store_addr_i = v.addr;
      store_data_i      = v.sdata;
      rd_addr_i         = v.rda;
      rd_write_enable_i = v.rdwe;
      rd_data_i         = 32'hAAAA5555;
   endtask

   task automatic idle_inputs();
      load_enable_i = 1'b0; store_enable_i = 1'b0; funct3_i = '0;
      load_store_addr_i = '0; store_data_i = '0; rd_data_i = '0;
      rd_addr_i = '0; rd_write_enable_i = 1'b0;
   endtask

   // Current cycle is T0 with the request already on the inputs.
   task automatic track(input int idx, input vec_t v);
      int unsigned cyc = 0, stalls = 0, rdc = 0, nwr0;
      bit          done = 1'b0;
      logic [31:0] a1 = '0, a2 = '0;
      nwr0 = wr_cnt;
      while (!done && cyc < 20) begin
         @(negedge clk);
         if (cyc == 0) begin
            chk($sformatf("v%0d_t0_stall", idx), 32'(stall_req_o), 32'd1);
            chk($sformatf("v%0d_t0_we", idx), 32'(rd_write_enable_o), 32'd0);
            chk($sformatf("v%0d_t0_data", idx), rd_data_o, 32'd0);
         end
         if (cyc == 1) a1 = bus.ram_addr_o;
         if (cyc == 2) a2 = bus.ram_addr_o;
         if (stall_req_o) stalls++;
         if (cyc > 0 && stall_req_o && !bus.ram_wr_o) rdc++;
         if (cyc > 0 && !stall_req_o) begin
            done = 1'b1;
            chk($sformatf("v%0d_done_cyc", idx), cyc, v.exp_done);
            chk($sformatf("v%0d_data", idx), rd_data_o, v.exp_data);
            chk($sformatf("v%0d_we", idx), 32'(rd_write_enable_o), 32'(v.exp_we));
            if (!v.st) chk($sformatf("v%0d_rda", idx), 32'(rd_addr_o), 32'(v.rda));
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!done) chk($sformatf("v%0d_timeout", idx), 32'd0, 32'd1);
      @(posedge clk); #1;
      idle_inputs();
      chk($sformatf("v%0d_stalls", idx), stalls, v.exp_stalls);
      chk($sformatf("v%0d_rdcyc", idx), rdc, v.exp_rdc);
      chk($sformatf("v%0d_nwr", idx), wr_cnt - nwr0, v.exp_nwr);
      chk($sformatf("v%0d_a1", idx), a1, v.a1);
      chk($sformatf("v%0d_a2", idx), a2, v.a2);
   endtask

   initial begin
      //        st ld f3      addr          sdata         rda we pre_n pre           exp_data      we dn st rc nw a1            a2
      vecs[0] = mk(1, 0, 3'b010, 32'h00000100, 32'hDEADBEEF, 7,  1, 0, 32'h0,        32'h00000000, 0, 5, 5, 0, 4, 32'h00000100, 32'h00000101);
      vecs[1] = mk(0, 1, 3'b000, 32'h00000007, 32'h0,        5,  1, 1, 32'h80,       32'hFFFFFF80, 1, 3, 3, 2, 0, 32'h00000007, 32'h00000000);
      vecs[2] = mk(0, 1, 3'b100, 32'h00000007, 32'h0,        6,  1, 1, 32'h80,       32'h00000080, 1, 3, 3, 2, 0, 32'h00000007, 32'h00000000);
      vecs[3] = mk(0, 1, 3'b001, 32'hFFFFFFFF, 32'h0,        9,  1, 2, 32'h1234,     32'h00001234, 1, 4, 4, 3, 0, 32'hFFFFFFFF, 32'h00000000);
      vecs[4] = mk(0, 1, 3'b001, 32'h00000200, 32'h0,        10, 1, 2, 32'h8000,     32'hFFFF8000, 1, 4, 4, 3, 0, 32'h00000200, 32'h00000201);
      vecs[5] = mk(0, 1, 3'b101, 32'h00000200, 32'h0,        11, 1, 2, 32'h8000,     32'h00008000, 1, 4, 4, 3, 0, 32'h00000200, 32'h00000201);
      vecs[6] = mk(0, 1, 3'b010, 32'h00000300, 32'h0,        31, 1, 4, 32'h44332211, 32'h44332211, 1, 6, 6, 5, 0, 32'h00000300, 32'h00000301);
      vecs[7] = mk(0, 1, 3'b010, 32'h00000101, 32'h0,        2,  0, 0, 32'h0,        32'h99DEADBE, 0, 6, 6, 5, 0, 32'h00000101, 32'h00000102);
      vecs[8] = mk(1, 1, 3'b000, 32'h00000400, 32'h12345678, 12, 1, 0, 32'h0,        32'h00000000, 0, 2, 2, 0, 1, 32'h00000400, 32'h00000000);
      vecs[9] = mk(1, 0, 3'b001, 32'h00000500, 32'hCAFE1234, 13, 1, 0, 32'h0,        32'h00000000, 0, 3, 3, 0, 2, 32'h00000500, 32'h00000501);

      rst_n = 1'b0;
      idle_inputs();
      for (int k = 0; k < 4; k++) preload(32'h300 + 32'(k), vecs[6].pre[8*k +: 8]);
      preload(32'h104, 8'h99);

      // Reset held with a load pending: nothing may start until release.
      drive(vecs[6]);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rst_stall", 32'(stall_req_o), 32'd0);
         chk("rst_wr", 32'(bus.ram_wr_o), 32'd0);
         chk("rst_addr", bus.ram_addr_o, 32'd0);
      end
      chk("rst_pass_data", rd_data_o, 32'hAAAA5555);
      @(posedge clk); #1;
      rst_n = 1'b1;
      track(100, vecs[6]);

      // Pass-through, same cycle.
      @(posedge clk); #1;
      rd_data_i = 32'h5; rd_addr_i = 5'd3; rd_write_enable_i = 1'b1;
      #1;
      chk("pt_data", rd_data_o, 32'h5);
      chk("pt_addr", 32'(rd_addr_o), 32'd3);
      chk("pt_we", 32'(rd_write_enable_o), 32'd1);
      chk("pt_stall", 32'(stall_req_o), 32'd0);
      @(negedge clk);
      chk("pt_stall_neg", 32'(stall_req_o), 32'd0);
      idle_inputs();

      for (int i = 0; i < 10; i++) begin
         for (int unsigned k = 0; k < vecs[i].pre_n; k++)
            preload(vecs[i].addr + 32'(k), vecs[i].pre[8*k +: 8]);
         @(posedge clk); #1;
         drive(vecs[i]);
         track(i, vecs[i]);
      end

      chk("mem_100", 32'(mem[12'h100]), 32'hEF);
      chk("mem_101", 32'(mem[12'h101]), 32'hBE);
      chk("mem_102", 32'(mem[12'h102]), 32'hAD);
      chk("mem_103", 32'(mem[12'h103]), 32'hDE);
      chk("mem_400", 32'(mem[12'h400]), 32'h78);
      chk("mem_500", 32'(mem[12'h500]), 32'h34);
      chk("mem_501", 32'(mem[12'h501]), 32'h12);

      // Reset in the middle of an LW, while addressing byte 2.
      begin
         int unsigned nwr0;
         nwr0 = wr_cnt;
         @(posedge clk); #1;
         drive(vecs[6]);
         for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
         @(negedge clk);
         chk("mid_addr_k2", bus.ram_addr_o, 32'h302);
         #1;
         rst_n = 1'b0;
         #1;
         chk("mid_stall", 32'(stall_req_o), 32'd0);
         chk("mid_wr", 32'(bus.ram_wr_o), 32'd0);
         chk("mid_addr", bus.ram_addr_o, 32'd0);
         chk("mid_pass_data", rd_data_o, 32'hAAAA5555);
         idle_inputs();
         @(posedge clk); #1;
         rst_n = 1'b1;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_stall", 32'(stall_req_o), 32'd0);
            chk("post_we", 32'(rd_write_enable_o), 32'd0);
            chk("post_addr", bus.ram_addr_o, 32'd0);
         end
         chk("mid_nwr", wr_cnt - nwr0, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage. Sits between the execution stage and write-back, converting word/half/byte load and store requests into byte-serial transactions on a single 8-bit synchronous RAM port. Stalls the pipeline while a transaction is in flight, passes non-memory results through unchanged, and returns sign- or zero-extended load data toward the register file.

## Interface

Parameters:
- ADDR_WIDTH, 32, width of `ram_addr_o`; the low ADDR_WIDTH bits of the computed byte address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_enable_i  in  1  load request.
- store_enable_i  in  1  store request.
- load_store_addr_i  in  32  byte address of the access.
- funct3_i  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use 000/001/010.
- store_data_i  in  32  store data; the low bytes are used.
- rd_data_i  in  32  non-memory result to pass through.
- rd_addr_i  in  5  destination register.
- rd_write_enable_i  in  1  destination write enable.
- rd_data_o  out  32  write-back data.
- rd_addr_o  out  5  write-back register.
- rd_write_enable_o  out  1  write-back enable.
- stall_req_o  out  1  freeze the upstream stages and this stage's input register.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address.
- ram_wr_o  out  1  1 means write `ram_dout_o` at `ram_addr_o` this cycle.
- ram_dout_o  out  8  RAM write data.
- ram_din_i  in  8  RAM read data. Valid the cycle after the address is presented with `ram_wr_o` = 0.

## Operation

- Size n from funct3[1:0]: 00 gives 1, 01 gives 2, 1x gives 4. Extension: funct3[2]=0 sign-extends from bit 8n-1; funct3[2]=1 zero-extends.
- Byte k is at address (load_store_addr_i + k) mod 2^32, truncated to ADDR_WIDTH. Order is little-endian: byte k maps to data bits [8k+7:8k].
- States:
  - IDLE
  - LOAD (counter k = 0..n)
  - STORE (counter k = 0..n-1)
  - DONE
- IDLE, no request: combinational pass-through of rd_data_i, rd_addr_i and rd_write_enable_i. stall_req_o = 0.
- IDLE, request present: latch addr, funct3, store_data, rd_addr, rd_write_enable and n. Assert stall_req_o. Next state is STORE if store_enable_i, else LOAD.
  - Store wins if both enables are set.
  - Pass-through outputs are 0 this cycle.
- STORE k: ram_addr = addr+k, ram_wr = 1, ram_dout = store byte k. After k = n-1, go to DONE.
- LOAD k:
  - For k < n: ram_addr = addr+k, ram_wr = 0.
  - For k ≥ 1: capture ram_din_i into byte k-1.
  - After k = n, go to DONE.
- DONE:
  - stall_req_o = 0.
  - Load: rd_data_o = extended assembled data, rd_addr_o = latched value, rd_write_enable_o = latched value.
  - Store: rd_write_enable_o = 0, rd_data_o = 0.
  - Inputs are ignored in DONE (they still hold the same request). Next state is IDLE.
- In every state except STORE: ram_wr_o = 0 and ram_dout_o = 0. When not issuing, ram_addr_o = 0.
- Misaligned addresses are legal: bytes are simply sequential.

## Timing

- Reset (asynchronous, immediate) gives:
  - state IDLE, counter 0, all latches 0
  - ram_wr_o = 0, ram_addr_o = 0, ram_dout_o = 0, stall_req_o = 0
  - rd_* outputs in pass-through (0 while inputs are 0)
- Reset mid-transaction aborts the access. Already-written bytes remain in RAM. No write strobe occurs after rst_n falls.
- All RAM outputs and stall_req_o are combinational from state, counter and latches. The IDLE-accept term of stall_req_o is combinational from the enables.
- Request accepted in cycle T0:
  - Store: writes in T1..Tn, DONE in Tn+1. stall_req_o is high T0..Tn (n+1 cycles).
  - Load: addresses in T1..Tn, data captured T2..Tn+1, DONE in Tn+2. stall_req_o is high T0..Tn+1 (n+2 cycles).
  - For LW the stall lasts 6 cycles and the result appears in T6.
- Non-memory instructions have zero added latency and no stall.
- A new request can be accepted on the cycle after DONE. No back-to-back acceptance from DONE.

## Test plan

- Reset: hold rst_n=0 with load_enable_i=1, then release. Required: ram_wr_o=0 and stall_req_o=0 during reset; the request is accepted on the first cycle after release.
- SW, addr=0x100, data=0xDEADBEEF. Required: writes EF@0x100, BE@0x101, AD@0x102, DE@0x103 in T1..T4; stall high T0..T4; DONE in T5 with rd_write_enable_o=0.
- LB vs LBU, addr=0x7, RAM[0x7]=0x80. Required: LB returns 0xFFFFFF80 and LBU returns 0x00000080, both in T3; stall high T0..T2.
- LH, addr=0xFFFFFFFF, ADDR_WIDTH=32, RAM bytes {0x34, 0x12}. Required: address wraps to 0x0 for byte 1; rd_data_o=0x00001234 in T4.
- Pass-through: rd_data_i=0x5, rd_addr_i=3, no enables. Required: same-cycle outputs 0x5/3/1 with no stall. Then assert both enables with SB. Required: a store is performed and no RAM read occurs.
- Mid-LW reset: drop rst_n in LOAD at k=2. Required: outputs reset immediately; no DONE; after release the block is IDLE.
